toggle_sched: RTL



---
 rtl/toggle_sched_pkg.sv | 15 +
 rtl/toggle_sched_if.sv | 37 +++
 rtl/toggle_sched_rr_pick.sv | 38 +++
 rtl/toggle_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/toggle_sched_pkg.sv
// Shared types and constants for the toggle_sched scheduler.
// The optional build macro TOGGLE_SCHED_PRIO0_EN is consumed in toggle_sched.sv.
package toggle_sched_pkg;

    // Scheduler FSM: IDLE arbitrates, RUN emits the burst, END closes the grant.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_t;

    // A requested burst length of zero is served as this many toggles.
    localparam int unsigned LEN_ZERO_AS = 1;

endpackage : toggle_sched_pkg

// File: rtl/toggle_sched_if.sv
// Request/config and grant/toggle bundle between the requester logic and
// the toggle scheduler.
//
// Handshake: req_i is a level request per requester. A requester raises its
// bit and holds it until its grant ends (done_o pulse, or gnt_o falling).
// div_i/len_i are sampled on the edge that raises gnt_o and ignored after.
// Dropping the granted bit while the burst runs aborts that burst.
interface toggle_sched_if
    import toggle_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 8,
    parameter int LEN_W   = 6
);

    logic [NUM_REQ-1:0] req_i;
    logic [DIV_W-1:0]   div_i;
    logic [LEN_W-1:0]   len_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic               busy_o;
    logic               toggle_o;
    logic               done_o;
    state_t             state_o;   // FSM state, exposed for observation

    // Requester side.
    modport master (
        output req_i, div_i, len_i,
        input  gnt_o, busy_o, toggle_o, done_o, state_o
    );

    // Scheduler side.
    modport slave (
        input  req_i, div_i, len_i,
        output gnt_o, busy_o, toggle_o, done_o, state_o
    );

endinterface : toggle_sched_if

// File: rtl/toggle_sched_rr_pick.sv
// rr_pick: combinational find-first-set starting at a pointer, with wrap.
// Returns the index of the first set request at or above ptr (wrapping past
// N-1 to 0) and a valid flag. Generic enough for any round-robin arbiter.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;

    // Rotate so that the pointer position lands on bit 0, then scan upward;
    // the first hit is mapped back to an absolute index modulo N.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        idx = '0;
        vld = 1'b0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (!vld && rot[i]) begin
                vld = 1'b1;
                sum = {1'b0, ptr} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick

// File: rtl/toggle_sched.sv
// toggle_sched: round-robin scheduler sharing one square-wave toggle output
// between NUM_REQ requesters. Each grant produces max(len,1) toggles with a
// half-period of div+1 cycles, then the output returns to 0 and the
// scheduler rearbitrates.
// Optional build macro: TOGGLE_SCHED_PRIO0_EN -- requester 0 always wins
// arbitration when requesting and does not move the round-robin pointer.
module toggle_sched
    import toggle_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 8,
    parameter int LEN_W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    toggle_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Registered state.
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               tog_q, tog_d;
    logic               done_q, done_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   tcnt_q, tcnt_d;

    // Arbitration.
    logic [NUM_REQ-1:0] pick_req;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               prio0_hit;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [IDX_W-1:0]   ptr_next;

    // Burst control.
    logic               abort;
    logic               flip;
    logic               last;

`ifdef TOGGLE_SCHED_PRIO0_EN
    // Requester 0 bypasses the rotation; the others share round-robin.
    assign prio0_hit = bus.req_i[0];
    assign pick_req  = bus.req_i & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
    assign prio0_hit = 1'b0;
    assign pick_req  = bus.req_i;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .idx (win_idx),
        .vld (win_vld)
    );

    assign grant_idx = prio0_hit ? '0 : win_idx;
    assign grant_vld = prio0_hit | win_vld;
    assign ptr_next  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : grant_idx + IDX_W'(1);

    // The burst is abandoned as soon as the granted requester lets go.
    assign abort = ((gnt_q & bus.req_i) == '0);
    // Divider terminal count: flip the output on this edge.
    assign flip  = (cnt_q == div_q);
    // Final toggle of the burst. len_q is never 0, so len_q-1 cannot wrap.
    assign last  = flip && (tcnt_q == (len_q - LEN_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (grant_vld) state_d = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last) begin
                    state_d = ST_END;
                end
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values for each state.
    always_comb begin
        gnt_d  = gnt_q;
        busy_d = busy_q;
        tog_d  = tog_q;
        done_d = 1'b0;
        ptr_d  = ptr_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        tcnt_d = tcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                tog_d = 1'b0;
                if (grant_vld) begin
                    gnt_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
                    busy_d = 1'b1;
                    div_d  = bus.div_i;
                    len_d  = (bus.len_i == '0) ? LEN_W'(LEN_ZERO_AS) : bus.len_i;
                    cnt_d  = '0;
                    tcnt_d = '0;
                    if (!prio0_hit) begin
                        ptr_d = ptr_next;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    tog_d  = 1'b0;
                end else if (flip) begin
                    tog_d  = ~tog_q;
                    cnt_d  = '0;
                    tcnt_d = tcnt_q + LEN_W'(1);
                    if (last) begin
                        // Grant ends with the final flip; an odd burst leaves
                        // the output high for the END cycle only.
                        gnt_d  = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_END: begin
                tog_d = 1'b0;
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                tog_d  = 1'b0;
            end
        endcase
    end

    // Output, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            tog_q  <= 1'b0;
            done_q <= 1'b0;
            ptr_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            tcnt_q <= '0;
        end else begin
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
            tog_q  <= tog_d;
            done_q <= done_d;
            ptr_q  <= ptr_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign bus.gnt_o    = gnt_q;
    assign bus.busy_o   = busy_q;
    assign bus.toggle_o = tog_q;
    assign bus.done_o   = done_q;
    assign bus.state_o  = state_q;

endmodule : toggle_sched
